// File: rtl/gate_label_ctl.sv
// gate_label_ctl
// Wire-label controller for the garbled-circuit evaluator. Accepts one command
// per transaction (FETCH2, FETCH1, STORE), moves labels to and from an
// external label memory over a req/ack port and combines operands per gate
// type with point-and-permute pointer extraction. A single-entry forwarding
// register lets a fetch of the most recently stored wire bypass the memory.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (accept on both high)
//   cmd_op, gate_type        operation and gate kind
//   id_a, id_b, store_label  operand IDs and label to store
//   done                     one-cycle completion pulse
//   label_out, ctxt_point    result label and ciphertext-row pointer
//   fwd_hit                  with done: an operand came from the forward register
//   mem_req/we/addr/wdata    memory request, held until mem_ack
//   mem_ack, mem_rdata       one-cycle acknowledge with read data
module gate_label_ctl #(
  parameter int LABEL_W = 128,
  parameter int ID_W    = 13,
  parameter int FWD_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [1:0]         gate_type,
  input  logic [ID_W-1:0]    id_a,
  input  logic [ID_W-1:0]    id_b,
  input  logic [LABEL_W-1:0] store_label,
  output logic               done,
  output logic [LABEL_W-1:0] label_out,
  output logic [1:0]         ctxt_point,
  output logic               fwd_hit,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ID_W-1:0]    mem_addr,
  output logic [LABEL_W-1:0] mem_wdata,
  input  logic               mem_ack,
  input  logic [LABEL_W-1:0] mem_rdata
);

  localparam logic [1:0] OP_FETCH2 = 2'd0;
  localparam logic [1:0] OP_STORE  = 2'd2;

  typedef enum logic [2:0] {IDLE, OP_A, OP_B, WR, FIN} state_t;

  state_t             state;
  logic               two_q;      // two-operand gate (FETCH2 with AND/XOR)
  logic               and_q;      // gate is AND (free-XOR AND label masking)
  logic               store_q;
  logic [ID_W-1:0]    id_a_q;
  logic [ID_W-1:0]    id_b_q;
  logic [LABEL_W-1:0] st_q;
  logic [LABEL_W-1:0] a_q;
  logic [LABEL_W-1:0] b_q;
  logic               hit_q;
  logic               fwd_valid;
  logic [ID_W-1:0]    fwd_id;
  logic [LABEL_W-1:0] fwd_label;

  assign cmd_ready = (state == IDLE) && !rst;

  function automatic logic fwd_match(input logic vld, input logic [ID_W-1:0] fid,
                                     input logic [ID_W-1:0] id);
    return (FWD_EN != 0) && vld && (fid == id);
  endfunction

  // AND clears the LSB so the pointer bit of the combined label is not leaked.
  function automatic logic [LABEL_W-1:0] res_label(input logic two, input logic is_and,
                                                   input logic [LABEL_W-1:0] a,
                                                   input logic [LABEL_W-1:0] b);
    logic [LABEL_W-1:0] x;
    x = a ^ b;
    if (!two)       return a;
    else if (is_and) return {x[LABEL_W-1:1], 1'b0};
    else            return x;
  endfunction

  function automatic logic [1:0] res_point(input logic two, input logic [LABEL_W-1:0] a,
                                           input logic [LABEL_W-1:0] b);
    return two ? {a[0], b[0]} : {a[0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      label_out  <= '0;
      ctxt_point <= '0;
      fwd_hit    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fwd_valid  <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            id_a_q  <= id_a;
            id_b_q  <= id_b;
            st_q    <= store_label;
            and_q   <= (gate_type == 2'd0);
            two_q   <= (cmd_op == OP_FETCH2) && !gate_type[1];
            store_q <= (cmd_op == OP_STORE);
            hit_q   <= 1'b0;
            if (cmd_op == OP_STORE) begin
              state     <= WR;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= id_a;
              mem_wdata <= store_label;
              fwd_valid <= 1'b1;
              fwd_id    <= id_a;
              fwd_label <= store_label;
            end else begin
              state <= OP_A;
              // A forward hit resolves in-state without touching memory.
              if (!fwd_match(fwd_valid, fwd_id, id_a)) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= id_a;
              end
            end
          end
        end
        OP_A: begin
          if (fwd_match(fwd_valid, fwd_id, id_a_q) || (mem_req && mem_ack)) begin
            if (fwd_match(fwd_valid, fwd_id, id_a_q)) begin
              a_q   <= fwd_label;
              hit_q <= 1'b1;
            end else begin
              a_q <= mem_rdata;
            end
            // Second read is issued on the capture edge so FETCH2 needs no gap.
            if (two_q) begin
              state <= OP_B;
              if (fwd_match(fwd_valid, fwd_id, id_b_q)) begin
                mem_req <= 1'b0;
              end else begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= id_b_q;
              end
            end else begin
              state   <= FIN;
              mem_req <= 1'b0;
            end
          end
        end
        OP_B: begin
          if (fwd_match(fwd_valid, fwd_id, id_b_q)) begin
            b_q   <= fwd_label;
            hit_q <= 1'b1;
            state <= FIN;
          end else if (mem_req && mem_ack) begin
            b_q     <= mem_rdata;
            mem_req <= 1'b0;
            state   <= FIN;
          end
        end
        WR: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            state   <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
          if (store_q) begin
            label_out <= st_q;
            fwd_hit   <= 1'b0;
          end else begin
            label_out  <= res_label(two_q, and_q, a_q, b_q);
            ctxt_point <= res_point(two_q, a_q, b_q);
            fwd_hit    <= hit_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_label_ctl.sv
module tb_gate_label_ctl;

  localparam int LW = 128;
  localparam int IW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic [1:0]    cmd_op = '0, gate_type = '0;
  logic [IW-1:0] id_a = '0, id_b = '0;
  logic [LW-1:0] store_label = '0;

  logic          cmd_ready, done, fwd_hit, mem_req, mem_we, mem_ack;
  logic [LW-1:0] label_out, mem_wdata, mem_rdata;
  logic [1:0]    ctxt_point;
  logic [IW-1:0] mem_addr;

  logic          cmd_ready2, done2, fwd_hit2, mem_req2, mem_we2, mem_ack2;
  logic [LW-1:0] label_out2, mem_wdata2, mem_rdata2;
  logic [1:0]    ctxt_point2;
  logic [IW-1:0] mem_addr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_label_ctl #(.LABEL_W(LW), .ID_W(IW), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .gate_type(gate_type), .id_a(id_a), .id_b(id_b),
    .store_label(store_label), .done(done), .label_out(label_out),
    .ctxt_point(ctxt_point), .fwd_hit(fwd_hit), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  gate_label_ctl #(.LABEL_W(LW), .ID_W(IW), .FWD_EN(0)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .gate_type(gate_type), .id_a(id_a), .id_b(id_b),
    .store_label(store_label), .done(done2), .label_out(label_out2),
    .ctxt_point(ctxt_point2), .fwd_hit(fwd_hit2), .mem_req(mem_req2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata2));

  // Memory model for dut: programmable ack delay, stray-ack injection, preload.
  logic [LW-1:0] mem  [0:15];
  logic [LW-1:0] mem2 [0:15];
  int            ack_delay = 0;
  int            wait_cnt = 0;
  logic          stray_ack = 1'b0;
  logic          pre_we = 1'b0;
  logic [3:0]    pre_addr = '0;
  logic [LW-1:0] pre_data = '0;
  int            rd_cnt = 0, rd_cnt2 = 0, done_cnt = 0;
  logic          req_d = 1'b0, ack_d = 1'b0, unstable = 1'b0;
  logic [IW-1:0] addr_d = '0;

  assign mem_ack    = (mem_req && (wait_cnt >= ack_delay)) || stray_ack;
  assign mem_rdata  = mem[mem_addr[3:0]];
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = mem2[mem_addr2[3:0]];

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_ack && mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    else if (pre_we)                  mem[pre_addr] <= pre_data;
    if (mem_req && mem_ack && !mem_we) rd_cnt <= rd_cnt + 1;
    if (mem_req2 && mem_ack2 && mem_we2) mem2[mem_addr2[3:0]] <= mem_wdata2;
    if (mem_req2 && mem_ack2 && !mem_we2) rd_cnt2 <= rd_cnt2 + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_req && req_d && !ack_d && mem_addr != addr_d) unstable <= 1'b1;
    req_d  <= mem_req;
    ack_d  <= mem_ack;
    addr_d <= mem_addr;
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [LW-1:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one command to dut; lat = edges from accept to done (-1 on timeout).
  task automatic run(input logic [1:0] op, input logic [1:0] gt, input logic [IW-1:0] a,
                     input logic [IW-1:0] b, input logic [LW-1:0] lbl, output int lat);
    @(negedge clk);
    cmd_op = op; gate_type = gt; id_a = a; id_b = b; store_label = lbl; cmd_valid = 1'b1;
    chk("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic run2(input logic [1:0] op, input logic [IW-1:0] a,
                      input logic [LW-1:0] lbl, output int lat);
    @(negedge clk);
    cmd_op = op; gate_type = 2'd2; id_a = a; id_b = '0; store_label = lbl; cmd_valid2 = 1'b1;
    @(posedge clk); #1 cmd_valid2 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done2) begin lat = i; break; end
    end
  endtask

  localparam logic [LW-1:0] L7 = {{15{8'hAA}}, 8'hAB};
  localparam logic [LW-1:0] LX = 128'h5A5A_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [LW-1:0] LY = 128'hCAFE_0001;
  localparam logic [LW-1:0] M3 = 128'h1234_5;

  initial begin
    int lat, rd0, dc0;

    // Reset: outputs quiet, cmd_ready low while rst is high.
    preload(4'd5, 128'h0F);
    preload(4'd9, 128'h03);
    preload(4'd3, M3);
    @(posedge clk); #1;
    chk("rst_done", done, 0);
    chk("rst_label_out", label_out, 0);
    chk("rst_ctxt_point", ctxt_point, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("post_rst_cmd_ready", cmd_ready, 1);

    // FETCH2 AND, zero-wait memory.
    run(2'd0, 2'd0, 13'd5, 13'd9, '0, lat);
    chk("and_latency", lat, 3);
    chk("and_label", label_out, 128'h0C);
    chk("and_point", ctxt_point, 2'b11);
    chk("and_fwd_hit", fwd_hit, 0);
    @(posedge clk); #1 chk("done_one_cycle", done, 0);

    // STORE id 7, then FETCH2 XOR of 7 with itself served from the forward register.
    run(2'd2, 2'd0, 13'd7, 13'd0, L7, lat);
    chk("store_latency", lat, 2);
    chk("store_label", label_out, L7);
    chk("store_fwd_hit", fwd_hit, 0);
    chk("store_mem_written", mem[7], L7);
    rd0 = rd_cnt;
    run(2'd0, 2'd1, 13'd7, 13'd7, '0, lat);
    chk("xor_fwd_latency", lat, 3);
    chk("xor_fwd_no_read", rd_cnt, rd0);
    chk("xor_fwd_hit", fwd_hit, 1);
    chk("xor_fwd_label", label_out, 0);
    chk("xor_fwd_point", ctxt_point, 2'b11);

    // FETCH2 BUF with four wait cycles: one read, address held, single-operand result.
    ack_delay = 4;
    rd0 = rd_cnt;
    run(2'd0, 2'd2, 13'd3, 13'd9, '0, lat);
    ack_delay = 0;
    chk("buf_wait_latency", lat, 6);
    chk("buf_one_read", rd_cnt - rd0, 1);
    chk("buf_addr_stable", unstable, 0);
    chk("buf_label", label_out, M3);
    chk("buf_point", ctxt_point, 2'b10);
    chk("buf_fwd_hit", fwd_hit, 0);

    // FETCH1 and reserved op 3.
    run(2'd1, 2'd1, 13'd9, 13'd5, '0, lat);
    chk("fetch1_latency", lat, 2);
    chk("fetch1_label", label_out, 128'h03);
    chk("fetch1_point", ctxt_point, 2'b10);
    run(2'd3, 2'd0, 13'd5, 13'd9, '0, lat);
    chk("op3_latency", lat, 2);
    chk("op3_label", label_out, 128'h0F);

    // Forwarding disabled: same-id fetch after store goes to memory.
    run2(2'd2, 13'd4, LX, lat);
    chk("nofwd_store_latency", lat, 2);
    rd0 = rd_cnt2;
    run2(2'd1, 13'd4, '0, lat);
    chk("nofwd_fetch_latency", lat, 2);
    chk("nofwd_read_issued", rd_cnt2 - rd0, 1);
    chk("nofwd_fwd_hit", fwd_hit2, 0);
    chk("nofwd_label", label_out2, LX);
    chk("nofwd_point", ctxt_point2, 2'b00);
    chk("nofwd_ready", cmd_ready2, 1);

    // Reset during a delayed read abandons it; stray ack is ignored.
    ack_delay = 10;
    dc0 = done_cnt;
    @(negedge clk);
    cmd_op = 2'd1; gate_type = 2'd2; id_a = 13'd3; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    chk("midrst_req_active", mem_req, 1);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_req_dropped", mem_req, 0);
    @(negedge clk) begin rst = 1'b0; ack_delay = 0; end
    @(negedge clk) stray_ack = 1'b1;
    @(negedge clk) stray_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - dc0, 0);
    chk("midrst_req_idle", mem_req, 0);
    chk("midrst_ready", cmd_ready, 1);
    // Forward register was cleared, so id 7 must come from memory now.
    rd0 = rd_cnt;
    run(2'd1, 2'd2, 13'd7, 13'd0, '0, lat);
    chk("after_rst_latency", lat, 2);
    chk("after_rst_read", rd_cnt - rd0, 1);
    chk("after_rst_fwd_hit", fwd_hit, 0);
    chk("after_rst_label", label_out, L7);

    // Back-to-back: cmd_valid held across STORE then FETCH1 of the same id.
    @(negedge clk);
    cmd_op = 2'd2; gate_type = 2'd2; id_a = 13'd2; store_label = LY; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_op = 2'd1;
    @(posedge clk); #1 chk("b2b_no_early_done", done, 0);
    @(posedge clk); #1;
    chk("b2b_store_done", done, 1);
    chk("b2b_ready_in_done", cmd_ready, 1);
    chk("b2b_store_label", label_out, LY);
    @(posedge clk); #1 cmd_valid = 1'b0;
    chk("b2b_accepted", cmd_ready, 0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    chk("b2b_fetch_latency", lat, 2);
    chk("b2b_fetch_hit", fwd_hit, 1);
    chk("b2b_fetch_label", label_out, LY);
    chk("b2b_fetch_point", ctxt_point, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_label_ctl.md
# gate_label_ctl

Parametrised wire-label controller for the garbled-circuit evaluator datapath. It accepts one command per transaction: fetch two operand labels, fetch one operand label, or store a label. It drives an external label memory over a request/acknowledge port and combines operands per gate type, including point-and-permute pointer extraction. A single-entry store-forwarding register lets a fetch of the most recently stored wire skip the memory.

## Interface
- LABEL_W, 128, label width in bits (≥2)
- ID_W, 13, wire-ID width; label memory depth is 2^ID_W
- FWD_EN, 1, 1 enables store forwarding; 0 sends every fetch to memory
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE when rst low; command accepted on cmd_valid & cmd_ready
- cmd_op  in  2  0 FETCH2, 1 FETCH1, 2 STORE, 3 reserved (accepted, treated as FETCH1)
- gate_type  in  2  0 AND, 1 XOR, 2 BUF, 3 INV
- id_a  in  ID_W  first operand ID, or store target
- id_b  in  ID_W  second operand ID (FETCH2 only)
- store_label  in  LABEL_W  label to write (STORE)
- done  out  1  one-cycle completion pulse
- label_out  out  LABEL_W  result label, held until next done
- ctxt_point  out  2  ciphertext-row pointer, held until next done
- fwd_hit  out  1  valid with done: ≥1 operand came from the forward register
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 write, 0 read
- mem_addr  out  ID_W  memory address
- mem_wdata  out  LABEL_W  write data
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  LABEL_W  read data

## Operation
- All command fields are registered at acceptance. Inputs are ignored outside the accept cycle.
- States are IDLE, OP_A, OP_B, WR, FIN.
- IDLE transitions on accept:
  - FETCH2 with AND/XOR goes to OP_A.
  - FETCH2 with BUF/INV, FETCH1, and op 3 go to OP_A and skip OP_B.
  - STORE goes to WR.
- OP_A and OP_B behaviour:
  - If FWD_EN, fwd_valid, and the ID equals fwd_id, capture fwd_label. The phase takes 1 cycle and mem_req stays low.
  - Otherwise assert mem_req (mem_we=0, mem_addr=ID) and capture mem_rdata on mem_ack.
  - The phase ends in the cycle where the operand is captured. OP_A then goes to OP_B or FIN.
- WR:
  - Assert mem_req with mem_we=1, mem_addr=id_a, mem_wdata=store_label.
  - On ack, go to FIN.
  - fwd_valid, fwd_id and fwd_label are updated at the accept edge of a STORE.
- FIN: pulse done, update outputs, return to IDLE.
- Result rules (A = first operand, B = second operand):
  - FETCH2 AND: label_out = {(A^B)[LABEL_W-1:1], 1'b0}; ctxt_point = {A[0], B[0]}.
  - FETCH2 XOR: label_out = A^B; ctxt_point = {A[0], B[0]}.
  - Single-operand paths: label_out = A; ctxt_point = {A[0], 1'b0}.
  - STORE: label_out = store_label; ctxt_point unchanged; fwd_hit=0.
- mem_ack outside an active read/write phase is ignored.
- id_a == id_b is legal. Both phases run and each hits or misses independently.

## Timing
- Reset values:
  - done=0, label_out=0, ctxt_point=0, fwd_hit=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - fwd_valid=0, state=IDLE, cmd_ready=0 while rst high.
- mem_req rises the cycle after entering a memory phase. mem_addr, mem_we and mem_wdata are stable while mem_req is high, and mem_req drops the cycle after ack. A same-cycle ack counts as a one-cycle phase.
- Latency from the accept edge to done high, with zero-wait memory (ack in the first req cycle) or forward hits:
  - FETCH2: 3 cycles.
  - FETCH1: 2 cycles.
  - STORE: 2 cycles.
  - Each extra memory wait cycle adds 1.
- done, label_out, ctxt_point and fwd_hit update on the same edge. cmd_ready is high in the cycle done is high, so back-to-back commands are possible.
- Reset mid-transaction abandons it:
  - mem_req falls on the next edge.
  - No done is produced.
  - The forward register is cleared.
  - A late ack is ignored.

## Test plan
- Reset, then FETCH2 AND with mem[5]=0x…0F, mem[9]=0x…03 (zero-wait) -> done at +3, label_out=0x…0C, ctxt_point=2'b11, fwd_hit=0.
- STORE id 7 label 0xAA…AB, then FETCH2 XOR id_a=7, id_b=7 -> first done at +2 with label_out=0xAA…AB. Second done has no mem_req for the fetch, fwd_hit=1, label_out=0, ctxt_point=2'b11.
- FETCH2 BUF id 3 with memory ack delayed 4 cycles -> exactly one read, mem_addr stable throughout, done at +6, ctxt_point={A[0],0}.
- FWD_EN=0: STORE then FETCH1 of the same id -> fetch issues a memory read, fwd_hit=0, label_out equals the stored label.
- Assert rst during a delayed read -> mem_req low the next cycle, no done, a later stray mem_ack ignored. A subsequent FETCH1 completes normally.
- Back-to-back: cmd_valid held high for STORE then FETCH1 -> second command accepted in the done cycle of the first, no idle gap.
